// File: rtl/clk_div_prog.sv
// Programmable clock divider: square output s with a runtime half-period, a rising-edge tick,
// pause control and ratio reload that only takes effect at full-period boundaries.
module clk_div_prog #(
    parameter int          CNT_W        = 32,
    parameter int unsigned HALF_DEFAULT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] half_in,
    output logic             s,
    output logic             tick,
    output logic [CNT_W-1:0] half_cur,
    output logic             pend
);

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(HALF_DEFAULT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] shadow_nxt;
    logic [CNT_W-1:0] half_nxt;
    logic             s_nxt;
    logic             tick_nxt;
    logic             pend_nxt;
    logic             ld_ok;
    logic             term;
    logic             boundary;

    // half_cur is never zero, so half_cur-1 cannot wrap.
    assign ld_ok    = ld && (half_in != '0);
    assign term     = (cnt >= (half_cur - ONE));
    assign boundary = en && term && s;

    always_comb begin
        cnt_nxt    = cnt;
        s_nxt      = s;
        tick_nxt   = 1'b0;
        half_nxt   = half_cur;
        shadow_nxt = shadow;
        pend_nxt   = pend;

        if (en) begin
            if (term) begin
                cnt_nxt  = '0;
                s_nxt    = ~s;
                tick_nxt = ~s;
            end else begin
                cnt_nxt  = cnt + ONE;
            end

            // A load landing on the boundary bypasses the shadow and applies at once.
            if (boundary) begin
                if (ld_ok) begin
                    half_nxt   = half_in;
                    shadow_nxt = half_in;
                end else if (pend) begin
                    half_nxt   = shadow;
                end
                pend_nxt = 1'b0;
            end else if (ld_ok) begin
                shadow_nxt = half_in;
                pend_nxt   = 1'b1;
            end
        end else if (ld_ok) begin
            // Paused: nothing is in flight, so the new ratio applies immediately with s held.
            half_nxt   = half_in;
            shadow_nxt = half_in;
            cnt_nxt    = '0;
            pend_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            s        <= 1'b0;
            tick     <= 1'b0;
            half_cur <= HALF_RST;
            shadow   <= HALF_RST;
            pend     <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            s        <= s_nxt;
            tick     <= tick_nxt;
            half_cur <= half_nxt;
            shadow   <= shadow_nxt;
            pend     <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a phase-length model checked every cycle plus literal anchors.
module tb_clk_div_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        ld;
    logic [31:0] half_in;
    logic        s;
    logic        tick;
    logic [31:0] half_cur;
    logic        pend;

    int checks   = 0;
    int failures = 0;

    clk_div_prog #(.CNT_W(32), .HALF_DEFAULT(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ld       (ld),
        .half_in  (half_in),
        .s        (s),
        .tick     (tick),
        .half_cur (half_cur),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    // Model: a phase lasts m_half cycles; a full period ends when a high phase ends.
    logic        m_s      = 1'b0;
    logic        m_tick   = 1'b0;
    logic        m_pend   = 1'b0;
    logic [31:0] m_half   = 32'd2;
    logic [31:0] m_shadow = 32'd2;
    int unsigned m_done   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s = 1'b0; m_tick = 1'b0; m_pend = 1'b0;
            m_half = 32'd2; m_shadow = 32'd2; m_done = 0;
        end else if (!en) begin
            m_tick = 1'b0;
            if (ld && half_in != 0) begin
                m_half = half_in; m_shadow = half_in; m_pend = 1'b0; m_done = 0;
            end
        end else begin
            logic period_end;
            m_done     = m_done + 1;
            period_end = 1'b0;
            m_tick     = 1'b0;
            if (m_done == m_half) begin
                period_end = m_s;
                m_s        = !m_s;
                m_tick     = m_s;
                m_done     = 0;
            end
            if (period_end) begin
                if (ld && half_in != 0) begin
                    m_half = half_in; m_shadow = half_in;
                end else if (m_pend) begin
                    m_half = m_shadow;
                end
                m_pend = 1'b0;
            end else if (ld && half_in != 0) begin
                m_shadow = half_in; m_pend = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_s", {31'd0, s}, {31'd0, m_s});
        chk("model_tick", {31'd0, tick}, {31'd0, m_tick});
        chk("model_half_cur", half_cur, m_half);
        chk("model_pend", {31'd0, pend}, {31'd0, m_pend});
    end

    // Apply inputs for the next rising edge, then settle just after the following falling edge.
    task automatic step(input logic e, input logic l, input logic [31:0] h);
        en = e; ld = l; half_in = h;
        @(negedge clk);
        #1;
    endtask

    task automatic run_after_release(input string tag);
        chk({tag, "_c1_s"}, {31'd0, s}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk({tag, "_c2_s"}, {31'd0, s}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk({tag, "_c3_s"}, {31'd0, s}, 32'd1);
        chk({tag, "_c3_tick"}, {31'd0, tick}, 32'd1);
        step(1'b1, 1'b0, 32'd0);
        chk({tag, "_c4_s"}, {31'd0, s}, 32'd1);
        chk({tag, "_c4_tick"}, {31'd0, tick}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk({tag, "_c5_s"}, {31'd0, s}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk({tag, "_c6_s"}, {31'd0, s}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk({tag, "_c7_s"}, {31'd0, s}, 32'd1);
        chk({tag, "_c7_tick"}, {31'd0, tick}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; ld = 1'b0; half_in = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_half_cur", half_cur, 32'd2);
        chk("rst_pend", {31'd0, pend}, 32'd0);
        rst_n = 1'b1;
        run_after_release("rel1");

        // Load 5 mid high phase; takes effect at the 1->0 edge.
        step(1'b1, 1'b1, 32'd5);
        chk("ld5_pend", {31'd0, pend}, 32'd1);
        chk("ld5_half_held", half_cur, 32'd2);
        chk("ld5_s_high", {31'd0, s}, 32'd1);
        step(1'b1, 1'b0, 32'd0);
        chk("ld5_bnd_s", {31'd0, s}, 32'd0);
        chk("ld5_bnd_half", half_cur, 32'd5);
        chk("ld5_bnd_pend", {31'd0, pend}, 32'd0);
        repeat (4) step(1'b1, 1'b0, 32'd0);
        chk("ld5_low5_s", {31'd0, s}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("ld5_rise_s", {31'd0, s}, 32'd1);
        chk("ld5_rise_tick", {31'd0, tick}, 32'd1);

        // Paused load of 2 keeps s high, then pause 7 cycles at cnt=1.
        step(1'b0, 1'b1, 32'd2);
        chk("pld_half", half_cur, 32'd2);
        chk("pld_s", {31'd0, s}, 32'd1);
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk("pause_s", {31'd0, s}, 32'd1);
            chk("pause_tick", {31'd0, tick}, 32'd0);
        end
        step(1'b1, 1'b0, 32'd0);
        chk("resume_fall_s", {31'd0, s}, 32'd0);

        // Zero load ignored; last of 3 then 7 wins at boundary.
        step(1'b1, 1'b1, 32'd0);
        chk("ld0_pend", {31'd0, pend}, 32'd0);
        step(1'b1, 1'b1, 32'd3);
        step(1'b1, 1'b1, 32'd7);
        chk("ld37_pend", {31'd0, pend}, 32'd1);
        chk("ld37_half_held", half_cur, 32'd2);
        step(1'b1, 1'b0, 32'd0);
        chk("ld37_bnd_half", half_cur, 32'd7);
        chk("ld37_bnd_pend", {31'd0, pend}, 32'd0);

        // Load 1 exactly on the boundary cycle.
        repeat (13) step(1'b1, 1'b0, 32'd0);
        chk("pre_bnd_s", {31'd0, s}, 32'd1);
        step(1'b1, 1'b1, 32'd1);
        chk("byp_half", half_cur, 32'd1);
        chk("byp_s", {31'd0, s}, 32'd0);
        chk("byp_pend", {31'd0, pend}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("div2_a_tick", {31'd0, tick}, 32'd1);
        step(1'b1, 1'b0, 32'd0);
        chk("div2_b_s", {31'd0, s}, 32'd0);
        chk("div2_b_tick", {31'd0, tick}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("div2_c_tick", {31'd0, tick}, 32'd1);

        // Async reset with a load pending.
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'd4);
        chk("prerst_pend", {31'd0, pend}, 32'd1);
        chk("prerst_s", {31'd0, s}, 32'd1);
        ld = 1'b0; half_in = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s", {31'd0, s}, 32'd0);
        chk("arst_tick", {31'd0, tick}, 32'd0);
        chk("arst_half", half_cur, 32'd2);
        chk("arst_pend", {31'd0, pend}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        run_after_release("rel2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
